// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative unsigned multiply/divide unit, one radix-2 step per clock
// Shift-add multiply and restoring divide share the hi/lo working registers.
module mul_div_unit #(
   parameter int DATA_WIDTH   = 32,
   parameter int OPCTRL_WIDTH = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [OPCTRL_WIDTH-1:0] OpCtrl,
   input  logic [DATA_WIDTH-1:0]   op1,
   input  logic [DATA_WIDTH-1:0]   op2,
   output logic                    busy,
   output logic                    done,
   output logic [DATA_WIDTH-1:0]   RESULT,
   output logic                    DIVZ
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t                state_q, state_d;
   logic [1:0]            op_q;
   logic [DATA_WIDTH-1:0] m_q;
   logic [DATA_WIDTH-1:0] hi_q;
   logic [DATA_WIDTH-1:0] lo_q;
   logic [CW-1:0]         cnt_q;
   logic                  last_q;
   logic                  short_q;
   logic                  z_q;

   logic                  accept;
   logic                  legal;
   logic                  divzero;
   logic [DATA_WIDTH:0]   mul_sum;
   logic [DATA_WIDTH:0]   div_shift;
   logic [DATA_WIDTH:0]   div_diff;

   assign accept  = start && (state_q == IDLE);
   assign legal   = (OpCtrl <= OPCTRL_WIDTH'(3));
   assign divzero = legal && OpCtrl[1] && (op2 == '0);

   // hi_q is the upper product half for MUL/MULH and the partial remainder for DIV/REM
   assign mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : '0)};
   assign div_shift = {hi_q, lo_q[DATA_WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, m_q};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (last_q) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         op_q    <= '0;
         m_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         short_q <= 1'b0;
         z_q     <= 1'b0;
         RESULT  <= '0;
         DIVZ    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_q    <= OpCtrl[1:0];
                  cnt_q   <= CW'(DATA_WIDTH - 1);
                  hi_q    <= '0;
                  // illegal and divide-by-zero skip the iterations; their answer waits in lo_q
                  short_q <= !legal || divzero;
                  last_q  <= !legal || divzero;
                  z_q     <= divzero;
                  if (!legal) begin
                     m_q  <= '0;
                     lo_q <= '0;
                  end else if (divzero) begin
                     lo_q <= OpCtrl[0] ? op1 : '1;
                  end else if (OpCtrl[1]) begin
                     m_q  <= op2;
                     lo_q <= op1;
                  end else begin
                     m_q  <= op1;
                     lo_q <= op2;
                  end
               end
            end
            CALC: begin
               if (last_q) begin
                  DIVZ   <= z_q;
                  RESULT <= (!short_q && op_q[0]) ? hi_q : lo_q;
               end else begin
                  if (!op_q[1]) begin
                     hi_q <= mul_sum[DATA_WIDTH:1];
                     lo_q <= {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
                  end else if (!div_diff[DATA_WIDTH]) begin
                     hi_q <= div_diff[DATA_WIDTH-1:0];
                     lo_q <= {lo_q[DATA_WIDTH-2:0], 1'b1};
                  end else begin
                     hi_q <= div_shift[DATA_WIDTH-1:0];
                     lo_q <= {lo_q[DATA_WIDTH-2:0], 1'b0};
                  end
                  if (cnt_q == '0) begin
                     last_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q - CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed-vector bench for mul_div_unit
module tb_mul_div_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  OpCtrl;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        busy;
   logic        done;
   logic [31:0] RESULT;
   logic        DIVZ;

   int n_vec  = 0;
   int n_miss = 0;

   mul_div_unit #(.DATA_WIDTH(32), .OPCTRL_WIDTH(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .OpCtrl (OpCtrl),
      .op1    (op1),
      .op2    (op2),
      .busy   (busy),
      .done   (done),
      .RESULT (RESULT),
      .DIVZ   (DIVZ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issues one op; lat counts edges after the accept edge until done is seen.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z,
                         input int exp_lat, input bit poke, input bit hold);
      int lat;
      bit seen;
      OpCtrl = op;
      op1    = a;
      op2    = b;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      OpCtrl = 3'b101;
      op1    = ~a;
      op2    = b ^ 32'h5A5A_0F0F;
      check({tag, "_busy"}, 64'(busy), 64'd1);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 200) begin
         if (done) begin
            seen = 1'b1;
         end else begin
            if (poke && lat == 5) begin
               start  = 1'b1;
               OpCtrl = 3'b000;
               op1    = 32'd7;
               op2    = 32'd7;
            end
            if (poke && lat == 6) start = 1'b0;
            @(posedge clk); #1;
            lat++;
         end
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_result"}, 64'(RESULT), 64'(exp_r));
      check({tag, "_divz"}, 64'(DIVZ), 64'(exp_z));
      if (hold) begin
         start  = 1'b1;
         OpCtrl = 3'b000;
         op1    = 32'd2;
         op2    = 32'd2;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_done_pulse"}, 64'(done), 64'd0);
      check({tag, "_idle"}, 64'(busy), 64'd0);
      @(posedge clk); #1;
      check({tag, "_still_idle"}, 64'(busy), 64'd0);
      check({tag, "_held"}, 64'(RESULT), 64'(exp_r));
   endtask

   initial begin
      rst    = 1'b0;
      start  = 1'b0;
      OpCtrl = 3'b000;
      op1    = '0;
      op2    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'(RESULT), 64'd0);
      check("rst_divz", 64'(DIVZ), 64'd0);
      rst = 1'b1;

      run_op("mul_7x6",   3'b000, 32'd7,        32'd6,        32'd42,        1'b0, 33, 1'b0, 1'b0);
      run_op("mulh_ff",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 1'b0, 1'b0);
      run_op("mul_ff",    3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33, 1'b0, 1'b0);
      run_op("mulh_big",  3'b001, 32'h8000_0000, 32'h0000_0010, 32'h0000_0008, 1'b0, 33, 1'b0, 1'b0);
      run_op("div_100_7", 3'b010, 32'd100,      32'd7,        32'd14,        1'b0, 33, 1'b0, 1'b0);
      run_op("rem_100_7", 3'b011, 32'd100,      32'd7,        32'd2,         1'b0, 33, 1'b0, 1'b0);
      run_op("div_5_9",   3'b010, 32'd5,        32'd9,        32'd0,         1'b0, 33, 1'b0, 1'b0);
      run_op("div_max_1", 3'b010, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 1'b0, 33, 1'b0, 1'b0);
      run_op("rem_max_16",3'b011, 32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 1'b0, 33, 1'b0, 1'b0);
      run_op("div_by0",   3'b010, 32'h1234,     32'd0,        32'hFFFF_FFFF, 1'b1, 1,  1'b0, 1'b0);
      run_op("rem_by0",   3'b011, 32'h1234,     32'd0,        32'h0000_1234, 1'b1, 1,  1'b0, 1'b0);
      run_op("illegal",   3'b111, 32'h55,       32'h66,       32'h0,         1'b0, 1,  1'b0, 1'b1);
      run_op("mul_3x3",   3'b000, 32'd3,        32'd3,        32'd9,         1'b0, 33, 1'b1, 1'b0);

      OpCtrl = 3'b010;
      op1    = 32'd100;
      op2    = 32'd7;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("abort_busy_before", 64'(busy), 64'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_result", 64'(RESULT), 64'd0);
      check("abort_divz", 64'(DIVZ), 64'd0);
      rst = 1'b1;
      run_op("div_9_3",   3'b010, 32'd9,        32'd3,        32'd3,         1'b0, 33, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no summary expected summary before 2ms");
      $fatal(1);
   end

endmodule
